// File: rtl/ex_hazard_ctrl_if.sv
// Decode <-> EX-stage control bundle: the decoded ID instruction plus branch resolution in,
// issue/stall/flush, slot valids and forwarding selects out.
interface ex_hazard_ctrl_if #(
    parameter int REG_AW = 3
);
    logic              id_valid;
    logic [REG_AW-1:0] id_dest_reg;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_op1_reg;
    logic              id_op1_used;
    logic [REG_AW-1:0] id_op2_reg;
    logic              id_op2_used;
    logic              id_is_load;
    logic              id_is_multi;
    logic              ex_branch_taken;

    logic              issue;
    logic              stall_id;
    logic              flush_id;
    logic              ex_valid;
    logic              ex_hold;
    logic              mem_valid;
    logic              wb_valid;
    logic [1:0]        fwd_op1_sel;
    logic [1:0]        fwd_op2_sel;

    modport master (
        output id_valid, id_dest_reg, id_wr_en, id_op1_reg, id_op1_used,
               id_op2_reg, id_op2_used, id_is_load, id_is_multi, ex_branch_taken,
        input  issue, stall_id, flush_id, ex_valid, ex_hold, mem_valid, wb_valid,
               fwd_op1_sel, fwd_op2_sel
    );

    modport slave (
        input  id_valid, id_dest_reg, id_wr_en, id_op1_reg, id_op1_used,
               id_op2_reg, id_op2_used, id_is_load, id_is_multi, ex_branch_taken,
        output issue, stall_id, flush_id, ex_valid, ex_hold, mem_valid, wb_valid,
               fwd_op1_sel, fwd_op2_sel
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage pipeline controller: tracks EX/MEM/WB writers, issues ID into EX, inserts
// load-use and multi-cycle stalls, kills ID on taken branches and registers forwarding selects.
module ex_hazard_ctrl #(
    parameter int REG_AW    = 3,
    parameter int MC_CYCLES = 4
) (
    input logic               clk,
    input logic               rst_n,
    ex_hazard_ctrl_if.slave   bus
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              wr_en;
        logic              is_load;
    } ex_slot_t;

    localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);

    ex_slot_t          ex_q, ex_d;
    logic              mem_valid_q, mem_valid_d;
    logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic              wb_valid_q, wb_valid_d;
    logic [3:0]        mc_q, mc_d;
    logic [1:0]        fwd1_q, fwd1_d, fwd2_q, fwd2_d;

    logic hold, match1, match2, load_use, flush, stall, issue;

    // Younger producer wins; a load still in EX cannot forward (load-use stall covers it).
    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] src);
        if (!used)                                                    return 2'd0;
        if (ex_q.valid && ex_q.wr_en && !ex_q.is_load && src == ex_q.dest) return 2'd1;
        if (mem_valid_q && mem_wr_en_q && src == mem_dest_q)          return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        hold     = (mc_q != 4'd0);
        match1   = bus.id_op1_used & ex_q.valid & ex_q.wr_en & (bus.id_op1_reg == ex_q.dest);
        match2   = bus.id_op2_used & ex_q.valid & ex_q.wr_en & (bus.id_op2_reg == ex_q.dest);
        load_use = bus.id_valid & ex_q.is_load & (match1 | match2);
        flush    = ex_q.valid & bus.ex_branch_taken & ~hold;
        stall    = ~flush & bus.id_valid & (load_use | hold);
        issue    = bus.id_valid & ~stall & ~flush;
    end

    // NOTE: every next-state variable gets a default first so no path infers a latch.
    always_comb begin
        ex_d        = ex_q;
        mem_valid_d = mem_valid_q;
        mem_dest_d  = mem_dest_q;
        mem_wr_en_d = mem_wr_en_q;
        wb_valid_d  = wb_valid_q;
        mc_d        = mc_q;
        fwd1_d      = fwd1_q;
        fwd2_d      = fwd2_q;

        wb_valid_d = mem_valid_q;
        if (hold) begin
            mc_d        = mc_q - 4'd1;
            mem_valid_d = 1'b0;
            mem_dest_d  = '0;
            mem_wr_en_d = 1'b0;
        end else begin
            mem_valid_d = ex_q.valid;
            mem_dest_d  = ex_q.dest;
            mem_wr_en_d = ex_q.wr_en;
            ex_d        = '0;
            if (issue) begin
                ex_d.valid   = 1'b1;
                ex_d.dest    = bus.id_dest_reg;
                ex_d.wr_en   = bus.id_wr_en;
                ex_d.is_load = bus.id_is_load;
                fwd1_d       = fwd_sel(bus.id_op1_used, bus.id_op1_reg);
                fwd2_d       = fwd_sel(bus.id_op2_used, bus.id_op2_reg);
                if (bus.id_is_multi) mc_d = MC_LOAD;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_valid_q <= 1'b0;
            mem_dest_q  <= '0;
            mem_wr_en_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            mc_q        <= '0;
            fwd1_q      <= '0;
            fwd2_q      <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_valid_q <= mem_valid_d;
            mem_dest_q  <= mem_dest_d;
            mem_wr_en_q <= mem_wr_en_d;
            wb_valid_q  <= wb_valid_d;
            mc_q        <= mc_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
        end
    end

    assign bus.issue       = issue;
    assign bus.stall_id    = stall;
    assign bus.flush_id    = flush;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_hold     = hold;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.fwd_op1_sel = fwd1_q;
    assign bus.fwd_op2_sel = fwd2_q;
endmodule
